// File: rtl/jtcps1_pkg.sv
// Shared definitions for the CPS1 object-table DMA.
// Holds the DMA FSM encoding, the table end marker and the object size.
package jtcps1_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_READ = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } obj_dma_st_e;

    localparam logic [7:0] OBJ_END_MARK = 8'hFF;
    localparam int         OBJ_SIZE     = 4;

endpackage

// File: rtl/jtcps1_obj_dma_ctl.sv
// Object DMA sequencer: FSM plus busreq/busack arbitration.
// In: clk, rst, cen, lvbl_fall, busack, vram_ok, last.
// Out: busreq, vram_cs, rd_bank, busy, start/word_done strobes.
module jtcps1_obj_dma_ctl
    import jtcps1_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic cen,
    input  logic lvbl_fall,
    input  logic busack,
    input  logic vram_ok,
    input  logic last,
    output logic busreq,
    output logic vram_cs,
    output logic rd_bank,
    output logic busy,
    output logic start,
    output logic word_done
);

    obj_dma_st_e state_q, state_d;
    logic        busreq_q, busreq_d;
    logic        cs_q, cs_d;
    logic        rd_bank_q, rd_bank_d;
    logic        busy_q, busy_d;

    assign start     = cen & (state_q == ST_IDLE) & lvbl_fall;
    // READ never looks at vram_ok, so an ok arriving as cs rises is dropped
    assign word_done = cen & (state_q == ST_WAIT) & busack & vram_ok;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (lvbl_fall) state_d = ST_REQ;
            ST_REQ:  if (busack) state_d = ST_READ;
            ST_READ: begin
                if (!busack)   state_d = ST_REQ;
                else if (cs_q) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!busack)      state_d = ST_REQ;
                else if (vram_ok) state_d = last ? ST_DONE : ST_READ;
            end
            ST_DONE: if (!busack) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        busreq_d  = (state_d == ST_REQ) | (state_d == ST_READ)
                  | (state_d == ST_WAIT);
        // the READ cycle right after WAIT is the table write slot:
        // the strobe stays low there and rises the cycle after
        cs_d      = (state_d == ST_WAIT)
                  | ((state_d == ST_READ) & (state_q != ST_WAIT));
        busy_d    = state_d != ST_IDLE;
        rd_bank_d = rd_bank_q
                  ^ ((state_d == ST_DONE) & (state_q != ST_DONE));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            busreq_q  <= 1'b0;
            cs_q      <= 1'b0;
            rd_bank_q <= 1'b0;
            busy_q    <= 1'b0;
        end else if (cen) begin
            state_q   <= state_d;
            busreq_q  <= busreq_d;
            cs_q      <= cs_d;
            rd_bank_q <= rd_bank_d;
            busy_q    <= busy_d;
        end
    end

    assign busreq  = busreq_q;
    assign vram_cs = cs_q;
    assign rd_bank = rd_bank_q;
    assign busy    = busy_q;

endmodule

// File: rtl/jtcps1_obj_dma.sv
// CPS1 object-table DMA: copies the VRAM sprite table into a
// double-buffered object table each vertical blank.
// Ports: clk/rst/cen, LVBL, obj_base, busreq/busack, vram_*, tbl_*,
// rd_bank, busy. Option: JTCPS1_OBJDMA_EARLYEND_EN ends at an FFxx attr.
module jtcps1_obj_dma
    import jtcps1_pkg::*;
#(
    parameter int WORDS = 1024,
    parameter int TAW   = 10
)(
    input  logic           clk,
    input  logic           rst,
    input  logic           cen,
    input  logic           LVBL,
    input  logic [15:0]    obj_base,
    output logic           busreq,
    input  logic           busack,
    output logic           vram_cs,
    output logic [16:0]    vram_addr,
    input  logic [15:0]    vram_data,
    input  logic           vram_ok,
    output logic           tbl_we,
    output logic [TAW:0]   tbl_addr,
    output logic [15:0]    tbl_din,
    output logic           rd_bank,
    output logic           busy
);

    logic           lvbl_q, lvbl_d;
    logic           fall_q, fall_d;
    logic [16:0]    base_q, base_d;
    logic [TAW:0]   cnt_q, cnt_d;
    logic           wbank_q, wbank_d;
    logic           tbl_we_q, tbl_we_d;
    logic [TAW:0]   tbl_addr_q, tbl_addr_d;
    logic [15:0]    tbl_din_q, tbl_din_d;
    logic           start, word_done, last, last_word;
    logic           unused_base;

    assign unused_base = ^obj_base[15:10];
    assign last_word   = cnt_q == (TAW+1)'(WORDS-1);

`ifdef JTCPS1_OBJDMA_EARLYEND_EN
    logic ext_q, ext_d, mark_hit;
    assign mark_hit = (cnt_q[1:0] == 2'(OBJ_SIZE-1))
                    & (vram_data[15:8] == OBJ_END_MARK);
    assign last     = last_word | mark_hit;
`else
    assign last     = last_word;
`endif

    jtcps1_obj_dma_ctl u_ctl (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .lvbl_fall (fall_q),
        .busack    (busack),
        .vram_ok   (vram_ok),
        .last      (last),
        .busreq    (busreq),
        .vram_cs   (vram_cs),
        .rd_bank   (rd_bank),
        .busy      (busy),
        .start     (start),
        .word_done (word_done)
    );

    always_comb begin
        lvbl_d     = LVBL;
        fall_d     = lvbl_q & ~LVBL;
        base_d     = base_q;
        cnt_d      = cnt_q;
        wbank_d    = wbank_q;
        tbl_we_d   = 1'b0;
        tbl_addr_d = tbl_addr_q;
        tbl_din_d  = tbl_din_q;
        if (start) begin
            base_d  = {obj_base[9:0], 7'd0};
            cnt_d   = '0;
            // the bank being filled is fixed for the whole frame
            wbank_d = ~rd_bank;
        end
        if (word_done) begin
            cnt_d      = cnt_q + (TAW+1)'(1);
            tbl_we_d   = 1'b1;
            tbl_din_d  = vram_data;
            tbl_addr_d = {wbank_q, cnt_q[TAW-1:0]};
        end
`ifdef JTCPS1_OBJDMA_EARLYEND_EN
        ext_d = 1'b0;
        if (word_done) begin
            ext_d = mark_hit & (cnt_d != (TAW+1)'(WORDS));
        end else if (ext_q) begin
            // terminate the list: stale entries past it must not render
            tbl_we_d   = 1'b1;
            tbl_din_d  = {OBJ_END_MARK, 8'h00};
            tbl_addr_d = {wbank_q,
                          cnt_q[TAW-1:0] + TAW'(OBJ_SIZE-1)};
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvbl_q     <= 1'b1;
            fall_q     <= 1'b0;
            base_q     <= '0;
            cnt_q      <= '0;
            wbank_q    <= 1'b1;
            tbl_we_q   <= 1'b0;
            tbl_addr_q <= '0;
            tbl_din_q  <= '0;
        end else if (cen) begin
            lvbl_q     <= lvbl_d;
            fall_q     <= fall_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            wbank_q    <= wbank_d;
            tbl_we_q   <= tbl_we_d;
            tbl_addr_q <= tbl_addr_d;
            tbl_din_q  <= tbl_din_d;
        end
    end

`ifdef JTCPS1_OBJDMA_EARLYEND_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      ext_q <= 1'b0;
        else if (cen) ext_q <= ext_d;
    end
`endif

    assign vram_addr = base_q + 17'(cnt_q);
    assign tbl_we    = tbl_we_q;
    assign tbl_addr  = tbl_addr_q;
    assign tbl_din   = tbl_din_q;

endmodule

// File: tb/tb_jtcps1_obj_dma.sv
// Directed scoreboard bench for jtcps1_obj_dma.
// Arbiter and VRAM responders run at the falling clock edge.
module tb_jtcps1_obj_dma;

    localparam int WORDS = 1024;
    localparam int TAW   = 10;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           cen = 1'b1;
    logic           LVBL = 1'b1;
    logic [15:0]    obj_base = '0;
    logic           busack = 1'b0;
    logic [15:0]    vram_data = '0;
    logic           vram_ok = 1'b0;
    logic           busreq, vram_cs, tbl_we, rd_bank, busy;
    logic [16:0]    vram_addr;
    logic [TAW:0]   tbl_addr;
    logic [15:0]    tbl_din;

    typedef struct {
        logic [TAW:0] addr;
        logic [15:0]  data;
    } exp_t;

    exp_t           sb[$];
    exp_t           mon_e;
    int             checks = 0;
    int             errors = 0;
    int             frame_writes = 0;
    int             hi_cnt = 0;
    int             wcnt[WORDS];
    logic           grant_en = 1'b1;
    logic           spur_ack = 1'b0;
    logic           ok_always = 1'b0;
    logic           cs_prev = 1'b0;
    logic           got_first = 1'b0;
    logic [16:0]    first_addr = '0;
    logic [16:0]    mark_addr = '1;
    logic           rd_exp = 1'b0;

    jtcps1_obj_dma #(.WORDS(WORDS), .TAW(TAW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .LVBL      (LVBL),
        .obj_base  (obj_base),
        .busreq    (busreq),
        .busack    (busack),
        .vram_cs   (vram_cs),
        .vram_addr (vram_addr),
        .vram_data (vram_data),
        .vram_ok   (vram_ok),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_din   (tbl_din),
        .rd_bank   (rd_bank),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_rd(input logic [16:0] a);
        if (a == mark_addr) return 16'hFF00;
        return a[15:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // arbiter, zero-wait VRAM and table-write monitor
    initial forever begin
        @(negedge clk);
        busack    = (grant_en & busreq) | spur_ack;
        vram_ok   = ok_always | cs_prev;
        cs_prev   = vram_cs;
        vram_data = mem_rd(vram_addr);
        if (busreq === 1'b1) hi_cnt++;
        if (vram_cs === 1'b1 && !got_first) begin
            first_addr = vram_addr;
            got_first  = 1'b1;
        end
        if (tbl_we === 1'b1) begin
            frame_writes++;
            wcnt[tbl_addr[TAW-1:0]]++;
            chk("sb_has_entry", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("tbl_addr", 32'(tbl_addr), 32'(mon_e.addr));
                chk("tbl_din", 32'(tbl_din), 32'(mon_e.data));
            end
        end
    end

    task automatic push_frame(input logic [16:0] b, input int n,
                              input logic bank);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.addr = {bank, TAW'(i)};
            e.data = mem_rd(b + 17'(i));
            sb.push_back(e);
        end
    endtask

    task automatic start_frame(input logic [15:0] b, output int lat);
        obj_base     = b;
        frame_writes = 0;
        hi_cnt       = 0;
        got_first    = 1'b0;
        for (int i = 0; i < WORDS; i++) wcnt[i] = 0;
        @(negedge clk);
        LVBL = 1'b0;
        lat  = 0;
        while (busreq !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_done(input logic exp_rd);
        int t = 0;
        while (busreq !== 1'b0 && t < 8000) begin
            @(negedge clk);
            t++;
        end
        chk("busreq_release", 32'(busreq), 0);
        chk("rd_bank_at_release", 32'(rd_bank), 32'(exp_rd));
        LVBL = 1'b1;
        repeat (4) @(negedge clk);
        chk("busy_idle", 32'(busy), 0);
        chk("sb_drained", sb.size(), 0);
    endtask

    task automatic wait_writes(input int n);
        int t = 0;
        while (frame_writes < n && t < 5000) begin
            @(negedge clk);
            t++;
        end
        chk("reach_writes", 32'(frame_writes >= n), 1);
    endtask

    initial begin
        int lat;
        int act;

        repeat (3) @(negedge clk);
        chk("rst_busreq", 32'(busreq), 0);
        chk("rst_vram_cs", 32'(vram_cs), 0);
        chk("rst_tbl_we", 32'(tbl_we), 0);
        chk("rst_tbl_addr", 32'(tbl_addr), 0);
        chk("rst_tbl_din", 32'(tbl_din), 0);
        chk("rst_rd_bank", 32'(rd_bank), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // normal frame
        push_frame(17'h09180, WORDS, ~rd_exp);
        rd_exp = ~rd_exp;
        start_frame(16'h0123, lat);
        chk("start_latency", lat, 2);
        wait_done(rd_exp);
        chk("first_read_addr", 32'(first_addr), 32'h09180);
        chk("normal_writes", frame_writes, WORDS);
        chk("normal_cycles", hi_cnt, 3 * WORDS);

        // vram_ok stuck high
        ok_always = 1'b1;
        push_frame(17'h02280, WORDS, ~rd_exp);
        rd_exp = ~rd_exp;
        start_frame(16'h0045, lat);
        wait_done(rd_exp);
        ok_always = 1'b0;
        chk("stale_writes", frame_writes, WORDS);
        chk("stale_cycles", hi_cnt, 3 * WORDS);

        // grant loss around word 500
        push_frame(17'h10000, WORDS, ~rd_exp);
        rd_exp = ~rd_exp;
        start_frame(16'h0200, lat);
        wait_writes(500);
        grant_en = 1'b0;
        act = 0;
        repeat (10) begin
            @(negedge clk);
            if (busreq !== 1'b1) act++;
        end
        grant_en = 1'b1;
        chk("busreq_held", act, 0);
        wait_done(rd_exp);
        chk("grant_writes", frame_writes, WORDS);
        chk("w500_once", wcnt[500], 1);
        chk("grant_stalled", 32'(hi_cnt >= 3 * WORDS + 10), 1);

        // second LVBL fall mid-transfer
        push_frame(17'h09180, WORDS, ~rd_exp);
        rd_exp = ~rd_exp;
        start_frame(16'h0123, lat);
        repeat (100) @(negedge clk);
        LVBL = 1'b1;
        @(negedge clk);
        LVBL = 1'b0;
        wait_done(rd_exp);
        chk("refall_writes", frame_writes, WORDS);
        chk("refall_cycles", hi_cnt, 3 * WORDS);

        // busack pulse while idle
        frame_writes = 0;
        spur_ack = 1'b1;
        act = 0;
        repeat (6) begin
            @(negedge clk);
            if (busreq !== 1'b0 || busy !== 1'b0 || vram_cs !== 1'b0)
                act++;
        end
        spur_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_ack_ignored", act, 0);
        chk("idle_ack_writes", frame_writes, 0);

        // asynchronous reset at word 200
        push_frame(17'h09180, WORDS, ~rd_exp);
        start_frame(16'h0123, lat);
        wait_writes(200);
        rst  = 1'b1;
        LVBL = 1'b1;
        #1;
        chk("rst_mid_busreq", 32'(busreq), 0);
        chk("rst_mid_rd_bank", 32'(rd_bank), 32'(rd_exp));
        chk("rst_mid_busy", 32'(busy), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

`ifdef JTCPS1_OBJDMA_EARLYEND_EN
        mark_addr = 17'h00800 + 17'd43;
        push_frame(17'h00800, 44, ~rd_exp);
        mon_e.addr = {~rd_exp, TAW'(47)};
        mon_e.data = 16'hFF00;
        sb.push_back(mon_e);
        rd_exp = ~rd_exp;
        start_frame(16'h0010, lat);
        wait_done(rd_exp);
        chk("early_writes", frame_writes, 45);
        mark_addr = '1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jtcps1_obj_dma.md
# jtcps1_obj_dma

Object-table DMA engine for the CPS1 video side. At the start of each vertical blank it requests the 68000 bus through the `busreq`/`busack` arbitration pair and copies the sprite table out of VRAM into a double-buffered object table. When the copy ends it releases the bus and swaps banks. It is the requesting end of the CPU bus-sharing handshake that the main-CPU block answers.

## Interface
Parameters:
- `WORDS`, 1024: maximum words copied per frame (256 objects × 4 words).
- `TAW`, 10: object-table word address width; `WORDS` ≤ 2^TAW.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, asynchronous, active-high.
- `cen` in 1: clock enable; every state and counter advances only when `cen`=1.
- `LVBL` in 1: vertical blank, active-low.
- `obj_base` in 16: object base register. The VRAM word base address is `{obj_base[9:0],7'd0}`.
- `busreq` out 1: bus request to the CPU arbiter.
- `busack` in 1: bus granted.
- `vram_cs` out 1: VRAM read strobe.
- `vram_addr` out 17: VRAM word address [17:1].
- `vram_data` in 16: read data.
- `vram_ok` in 1: read data valid.
- `tbl_we` out 1: object-table write enable, one cycle per word.
- `tbl_addr` out TAW+1: object-table address. The MSB is the write bank (`~rd_bank`).
- `tbl_din` out 16: object-table write data.
- `rd_bank` out 1: bank the object renderer reads.
- `busy` out 1: high from start of request until bus release.

## Operation
- The FSM has five states: IDLE, REQ, READ, WAIT, DONE.
- IDLE: a registered falling edge of `LVBL` latches `obj_base`, clears `cnt` and moves to REQ.
- REQ: `busreq`=1. When `busack`=1, go to READ.
- READ: `vram_cs`=1 and `vram_addr` = base + `cnt`, added modulo 2^17. Go to WAIT.
- WAIT: `vram_cs` stays 1. Any `vram_ok` in the same cycle `vram_cs` rose is ignored as stale. On the first qualified `vram_ok`:
  - the cycle after, `tbl_we`=1, `tbl_din`=`vram_data`, `tbl_addr`=`{~rd_bank,cnt}`;
  - `cnt` increments;
  - if `cnt`==WORDS-1 (or an early-end condition holds, see Configuration), go to DONE; otherwise go to READ.
- DONE: `busreq`=0 and `rd_bank` toggles. Return to IDLE once `busack`=0.
- `busack` falling in READ/WAIT: drop `vram_cs`, discard any pending word (`cnt` unchanged) and return to REQ. The transfer resumes at the same `cnt`.
- A `LVBL` falling edge while not IDLE is ignored. No restart, no queueing.
- `busack`=1 while in IDLE is ignored.

## Timing
- Reset values: `busreq`=0, `vram_cs`=0, `tbl_we`=0, `tbl_addr`=0, `tbl_din`=0, `rd_bank`=0, `busy`=0, state IDLE.
- An asynchronous reset mid-transfer drops `busreq` immediately and leaves the partial bank unswapped.
- Start latency: `busreq` rises 2 `cen` cycles after the `LVBL` falling edge (1 cycle edge register, 1 cycle IDLE→REQ).
- Per-word cost: 1 cycle READ + (≥1 WAIT cycles until `vram_ok`) + 1 cycle write. At zero memory wait that is 3 `cen` cycles per word.
- `rd_bank` toggles in the same cycle that `busreq` falls.
- `busy` = (state ≠ IDLE).

## Configuration
- `JTCPS1_OBJDMA_EARLYEND_EN` defined: after writing word index 3 mod 4 (the attribute word) with `vram_data[15:8]`==8'hFF, the transfer ends; that word is still written. Unwritten entries of the bank keep stale data, so the block also writes 16'hFF00 to the next attribute slot. This costs one extra `tbl_we` cycle, not a VRAM read, and is skipped if `cnt`==WORDS.
- Macro undefined: exactly WORDS words are always copied and `vram_data` is not inspected.

## Structure
- Shared package `jtcps1_pkg` holds:
  - the state encoding constants;
  - the end marker 8'hFF;
  - the object size constant 4.
- Natural sub-module: `jtcps1_obj_dma_ctl`, containing the FSM plus `busreq`/`busack` handling. The counter, address adder and table write path stay in the top.

## Test plan
- Normal frame: `obj_base`=16'h0123, zero-wait VRAM. Expect:
  - reads start at 17'h09180;
  - exactly 1024 `tbl_we` pulses into bank 1;
  - `rd_bank` 0→1 at completion and `busreq` low.
- Stale-ok guard: `vram_ok` held high permanently. Expect each word to take 3 cycles with data matching the address, and no double writes.
- Grant loss: drop `busack` during word 500 for 10 cycles. Expect `busreq` to stay high, word 500 to be rewritten once, and a total of 1024 writes.
- Early end (macro on): attribute word at index 43 = 16'hFF00. Expect 44 data writes plus one 16'hFF00 write at index 47, then release.
- Spurious events: a second `LVBL` fall mid-transfer and a `busack` pulse in IDLE both cause no effect. An asynchronous `rst` at word 200 gives `busreq`=0 immediately and `rd_bank` unchanged.
